ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit in the EX stage; consumes ReadData1/ReadData2 and ALUOp from the DEC/EX register.
//  Produces the 64-bit {Hi,Lo} result that the Hi/Lo write-back selects (HiSrc/LoSrc) consume.
//  Drives a stall that freezes PC, IF/DEC and DEC/EX while an operation is in flight.
//  One radix-2 step per cycle.
// PARAMETERS
//  WIDTH  32  operand width; result is 2*WIDTH; iteration count = WIDTH
// PORTS
//  Clk        in   1        clock, rising edge
//  Rst        in   1        synchronous active-high reset
//  Start      in   1        request operation; sampled only in IDLE
//  Op         in   2        00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
//  OperandA   in   WIDTH    multiplicand / dividend (rs)
//  OperandB   in   WIDTH    multiplier / divisor (rt)
//  Cancel     in   1        abort: branch/jump flush of the issuing instruction
//  Stall      out  1        hold upstream pipeline registers
//  Done       out  1        one-cycle pulse; HiLoOut valid and new
//  HiLoOut    out  2*WIDTH  {Hi,Lo}: product; for divide {remainder,quotient}
//  DivByZero  out  1        set with Done when divisor was 0; else 0
// BEHAVIOUR
//  Reset: state=IDLE; Done=0, DivByZero=0, HiLoOut=0, Stall=0; internal counter/accumulators cleared.
//   Rst mid-operation aborts immediately with no Done.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//  IDLE:
//   - Start & ~Cancel latches Op and operands.
//   - Captures |A|, |B| and result-sign bits for signed ops; MIN_INT magnitude is 2^31 unsigned.
//   - Loads counter=WIDTH and goes to RUN.
//   - Divide with B==0 goes straight to DONE.
//  RUN:
//   - One shift-add (mult) or shift-subtract restoring step (div) per cycle.
//   - Counter decrements; at counter==1 the step completes and the sign fix-up is applied.
//   - Then go to DONE.
//  Sign rules:
//   - product negated if signs differ;
//   - quotient negated if signs differ;
//   - remainder takes the dividend's sign.
//   - All arithmetic is 2*WIDTH wide, truncation-free.
//  DONE:
//   - Done=1 for exactly one cycle; HiLoOut updated on entry to DONE; next state IDLE.
//  Latency: Start accepted at edge 0 -> Done high during cycle WIDTH+1 (33 for default).
//   Divide-by-zero: Done during cycle 1.
//  Divide by zero: HiLoOut={OperandA, all-ones}, DivByZero=1.
//  Stall = (state==RUN) | (state==IDLE & Start & ~Cancel & ~div0). Combinational; low in DONE.
//  Start while RUN/DONE: ignored, no queueing.
//  Cancel in RUN: next state IDLE, no Done, HiLoOut keeps its previous value.
//   Cancel in DONE has no effect.
//   Cancel & Start together in IDLE: not accepted.
//  HiLoOut holds its last result until the next Done; DivByZero clears on the next accepted Start.
// CONFIGURATION
//  MULDIV_EARLY_EXIT_EN
//   Defined:
//    - Multiply leaves RUN as soon as the remaining unshifted multiplier bits are all zero.
//    - Shift-align the accumulator in the final step.
//    - Done arrives at cycle k+1, where k = index of the highest set bit of |B| plus 1, minimum 1.
//    - B==0 multiply gives Done at cycle 2.
//    - Divide latency unchanged.
//   Undefined: fixed WIDTH iterations for all ops.
// TESTING
//  1. MULTU A=3, B=5 -> Done at cycle 33, HiLoOut=64'h0000_0000_0000_000F, Stall high cycles 0..32.
//  2. MULT A=32'hFFFF_FFFF (-1), B=2 -> HiLoOut=64'hFFFF_FFFF_FFFF_FFFE.
//     MULT A=B=32'h8000_0000 -> 64'h4000_0000_0000_0000.
//  3. DIV A=-7, B=2 -> HiLoOut={32'hFFFF_FFFF, 32'hFFFF_FFFD}, DivByZero=0.
//     DIVU A=100, B=7 -> {2, 14}.
//  4. DIVU A=32'h1234, B=0 -> Done at cycle 1, HiLoOut={32'h1234, 32'hFFFF_FFFF}, DivByZero=1.
//  5. MULTU 6*7, Cancel at cycle 10 -> Stall low from cycle 11, no Done, HiLoOut keeps prior value.
//     Start at cycle 5 of a run -> ignored.
//     Rst at cycle 12 -> all outputs 0 next cycle.
//  6. With MULDIV_EARLY_EXIT_EN: MULTU A=9, B=3 -> Done at cycle 3, HiLoOut=27.
//     Without the macro -> Done at cycle 33.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative radix-2 multiply/divide unit for the EX stage.
// Produces {Hi,Lo} = product, or {remainder, quotient} for divides, one step per cycle.
// Optional build macro: MULDIV_EARLY_EXIT_EN (multiply stops once the remaining multiplier bits are zero).
module ex_muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Start,
    input  logic [1:0]         Op,
    input  logic [WIDTH-1:0]   OperandA,
    input  logic [WIDTH-1:0]   OperandB,
    input  logic               Cancel,
    output logic               Stall,
    output logic               Done,
    output logic [2*WIDTH-1:0] HiLoOut,
    output logic               DivByZero
);

    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [W2-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [W2-1:0]    hilo_q, hilo_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic             is_signed_c;
    logic             accept_c;
    logic             div0_c;
    logic [WIDTH-1:0] abs_a_c, abs_b_c;
    logic [W2-1:0]    acc_step_c, prod_fix_c;
    logic [WIDTH:0]   shifted_c, diff_c;
    logic             ge_c;
    logic [WIDTH-1:0] rem_step_c, quo_step_c, rem_fix_c, quo_fix_c;
    logic             last_c;

    // Operand decode: magnitudes for signed ops (MIN_INT maps to 2^(WIDTH-1) unsigned)
    always_comb begin
        is_signed_c = ~Op[0];
        accept_c    = Start & ~Cancel;
        div0_c      = Op[1] & (OperandB == '0);
        abs_a_c     = (is_signed_c & OperandA[WIDTH-1]) ? WIDTH'(-OperandA) : OperandA;
        abs_b_c     = (is_signed_c & OperandB[WIDTH-1]) ? WIDTH'(-OperandB) : OperandB;
    end

    // One shift-add / restoring shift-subtract step plus the final sign fix-up
    always_comb begin
        acc_step_c = work_q[0] ? W2'(acc_q + mcand_q) : acc_q;
        prod_fix_c = neg_res_q ? W2'(-acc_step_c) : acc_step_c;

        shifted_c  = {rem_q, work_q[WIDTH-1]};
        diff_c     = (WIDTH+1)'(shifted_c - {1'b0, dvsr_q});
        ge_c       = ~diff_c[WIDTH];
        rem_step_c = ge_c ? diff_c[WIDTH-1:0] : shifted_c[WIDTH-1:0];
        quo_step_c = {work_q[WIDTH-2:0], ge_c};
        quo_fix_c  = neg_res_q ? WIDTH'(-quo_step_c) : quo_step_c;
        rem_fix_c  = neg_rem_q ? WIDTH'(-rem_step_c) : rem_step_c;

`ifdef MULDIV_EARLY_EXIT_EN
        last_c = (cnt_q == CW'(1)) | (~is_div_q & (work_q[WIDTH-1:1] == '0));
`else
        last_c = (cnt_q == CW'(1));
`endif
    end

    // Upstream hold: busy in RUN, or an operation being accepted this cycle
    always_comb begin
        Stall = (state_q == S_RUN) | ((state_q == S_IDLE) & accept_c & ~div0_c);
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        work_d    = work_q;
        rem_d     = rem_q;
        dvsr_d    = dvsr_q;
        hilo_d    = hilo_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    dbz_d = 1'b0;
                    if (div0_c) begin
                        hilo_d  = {OperandA, {WIDTH{1'b1}}};
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        is_div_d  = Op[1];
                        neg_res_d = is_signed_c & (OperandA[WIDTH-1] ^ OperandB[WIDTH-1]);
                        neg_rem_d = is_signed_c & OperandA[WIDTH-1];
                        cnt_d     = CW'(WIDTH);
                        acc_d     = '0;
                        mcand_d   = {{WIDTH{1'b0}}, abs_a_c};
                        work_d    = Op[1] ? abs_a_c : abs_b_c;
                        rem_d     = '0;
                        dvsr_d    = abs_b_c;
                        state_d   = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (Cancel) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    if (is_div_q) begin
                        rem_d  = rem_step_c;
                        work_d = quo_step_c;
                    end else begin
                        acc_d   = acc_step_c;
                        mcand_d = mcand_q << 1;
                        work_d  = work_q >> 1;
                    end
                    if (last_c) begin
                        hilo_d  = is_div_q ? {rem_fix_c, quo_fix_c} : prod_fix_c;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, synchronous reset
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            work_q    <= '0;
            rem_q     <= '0;
            dvsr_q    <= '0;
            hilo_q    <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            work_q    <= work_d;
            rem_q     <= rem_d;
            dvsr_q    <= dvsr_d;
            hilo_q    <= hilo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign Done      = done_q;
    assign HiLoOut   = hilo_q;
    assign DivByZero = dbz_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: stimulus pushes expected results, a monitor checks each Done.
module tb_ex_muldiv_unit;

    localparam int unsigned W = 32;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic          Start = 1'b0;
    logic [1:0]    Op = 2'b00;
    logic [W-1:0]  OperandA = '0;
    logic [W-1:0]  OperandB = '0;
    logic          Cancel = 1'b0;
    logic          Stall;
    logic          Done;
    logic [2*W-1:0] HiLoOut;
    logic          DivByZero;

    ex_muldiv_unit #(.WIDTH(W)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op),
        .OperandA(OperandA), .OperandB(OperandB), .Cancel(Cancel),
        .Stall(Stall), .Done(Done), .HiLoOut(HiLoOut), .DivByZero(DivByZero)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] hilo;
        logic        dbz;
        int          when;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          n_done = 0;
    logic [63:0] last_hilo = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero, remainder follows dividend
    function automatic logic [63:0] ref_hilo(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb2, q, r;
        longint unsigned ua, ub, uq, ur;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        case (op)
            2'b00: return 64'(sa * sb2);
            2'b01: return ua * ub;
            2'b10: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb2;
                r = sa % sb2;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    function automatic int lat_of(input logic [1:0] op, input logic [31:0] b);
`ifdef MULDIV_EARLY_EXIT_EN
        logic [31:0] mb;
        int k;
`endif
        if (op[1]) return (b == 0) ? 1 : W + 1;
`ifdef MULDIV_EARLY_EXIT_EN
        mb = (op == 2'b00 && b[31]) ? -b : b;
        k = 1;
        for (int i = 0; i < W; i++) if (mb[i]) k = i + 1;
        return k + 1;
`else
        return W + 1;
`endif
    endfunction

    // Monitor: every Done must match the oldest outstanding expectation
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge Clk);
            if (!Rst && Done) begin
                n_done++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got Done=1 expected none (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("hilo", HiLoOut, e.hilo);
                    chk("div_by_zero", 64'(DivByZero), 64'(e.dbz));
                    chk("done_cycle", 64'(cyc), 64'(e.when));
                end
            end
        end
    endtask

    // Present an operation for one cycle (cycle 0); optionally register the expected result
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, output int c0, output int prev);
        exp_t e;
        logic div0;
        @(negedge Clk);
        Op = op; OperandA = a; OperandB = b; Start = 1'b1;
        c0   = cyc;
        prev = n_done;
        div0 = op[1] && (b == 0);
        if (push) begin
            e.hilo = ref_hilo(op, a, b);
            e.dbz  = div0;
            e.when = c0 + lat_of(op, b);
            sb.push_back(e);
            last_hilo = e.hilo;
        end
        #1 chk("stall_cycle0", 64'(Stall), 64'(!div0));
        @(negedge Clk);
        Start = 1'b0;
        OperandA = $urandom;
        OperandB = $urandom;
        #1;
    endtask

    task automatic wait_done(input int prev);
        int budget = 0;
        while (n_done == prev && budget < 60) begin
            @(negedge Clk);
            #1;
            budget++;
        end
        if (n_done == prev) chk("done_timeout", 64'(0), 64'(1));
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int c0, prev;
        issue(op, a, b, 1'b1, c0, prev);
        wait_done(prev);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] corners [6];
        corners[0] = 32'h0;          corners[1] = 32'h1;
        corners[2] = 32'hFFFF_FFFF;  corners[3] = 32'h8000_0000;
        corners[4] = 32'h7FFF_FFFF;  corners[5] = 32'h0000_0007;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        if ($urandom_range(0, 2) == 0) return 32'($urandom_range(0, 255));
        return $urandom;
    endfunction

    initial begin
        int c0, prev;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge Clk);
        chk("rst_done", 64'(Done), 64'(0));
        chk("rst_hilo", HiLoOut, 64'(0));
        chk("rst_dbz", 64'(DivByZero), 64'(0));
        chk("rst_stall", 64'(Stall), 64'(0));
        Rst = 1'b0;

        // MULTU 3*5 with Stall profile and an ignored Start at cycle 5
        issue(2'b01, 32'd3, 32'd5, 1'b1, c0, prev);
        while (cyc < c0 + lat_of(2'b01, 32'd5)) begin
            if (cyc == c0 + 5) begin
                Op = 2'b01; OperandA = 32'd100; OperandB = 32'd100; Start = 1'b1;
            end else begin
                Start = 1'b0;
            end
            #1 chk("stall_run", 64'(Stall), 64'(1));
            @(negedge Clk);
        end
        Start = 1'b0;
        #1 chk("stall_done", 64'(Stall), 64'(0));
        wait_done(prev);

        // Directed signed/unsigned and divide cases
        run_op(2'b00, 32'hFFFF_FFFF, 32'd2);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        run_op(2'b11, 32'd100, 32'd7);
        run_op(2'b11, 32'h0000_1234, 32'd0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'b01, 32'd9, 32'd3);
        run_op(2'b01, 32'd9, 32'd0);

        // Cancel during RUN: no Done, result held
        issue(2'b01, 32'd6, 32'd7, 1'b0, c0, prev);
        while (cyc < c0 + 10) @(negedge Clk);
        Cancel = 1'b1;
        @(negedge Clk);
        Cancel = 1'b0;
        #1 chk("stall_after_cancel", 64'(Stall), 64'(0));
        repeat (40) @(negedge Clk);
        chk("hilo_held_cancel", HiLoOut, last_hilo);

        // Start with Cancel in IDLE is not accepted
        @(negedge Clk);
        Op = 2'b01; OperandA = 32'd4; OperandB = 32'd4; Start = 1'b1; Cancel = 1'b1;
        #1 chk("stall_start_cancel", 64'(Stall), 64'(0));
        @(negedge Clk);
        Start = 1'b0; Cancel = 1'b0;
        #1 chk("stall_not_accepted", 64'(Stall), 64'(0));
        repeat (40) @(negedge Clk);
        chk("hilo_held_reject", HiLoOut, last_hilo);

        // Divide by zero then a fresh op clears DivByZero; then reset mid-run
        run_op(2'b10, 32'hDEAD_BEEF, 32'd0);
        run_op(2'b11, 32'd50, 32'd5);
        issue(2'b01, 32'd11, 32'd13, 1'b0, c0, prev);
        while (cyc < c0 + 12) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        chk("midrst_done", 64'(Done), 64'(0));
        chk("midrst_hilo", HiLoOut, 64'(0));
        chk("midrst_dbz", 64'(DivByZero), 64'(0));
        chk("midrst_stall", 64'(Stall), 64'(0));
        last_hilo = '0;
        repeat (40) @(negedge Clk);
        chk("hilo_after_rst", HiLoOut, last_hilo);

        // Randomized operations against the reference model
        for (int n = 0; n < 40; n++) begin
            run_op(2'($urandom_range(0, 3)), pick(), pick());
        end

        repeat (5) @(negedge Clk);
        if (sb.size() != 0) chk("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
